wb_gpio_irq: RTL

Parametrised Wishbone B3 classic-cycle GPIO controller. Successor to the fixed 8-bit gpio slave.
- Width is configurable.
- Adds metastability synchronisers, atomic set/clear of output bits, and per-bit rising/falling-edge interrupts with a write-1-to-clear status register.
- Sits as an intercon slave beside the uart and ram. irq_o feeds the CPU interrupt input.

---
 rtl/wb_gpio_pkg.sv | 23 ++
 rtl/wb_gpio_irq_if.sv | 23 ++
 rtl/gpio_sync_edge.sv | 89 ++++++++
 rtl/wb_gpio_irq.sv | 127 ++++++++++++
 4 files changed

// File: rtl/wb_gpio_pkg.sv
// rtl/wb_gpio_pkg.sv - register offsets, reset value and byte-lane helper for wb_gpio_irq
package wb_gpio_pkg;

    localparam logic [2:0] GPIO_REG_IN      = 3'd0;
    localparam logic [2:0] GPIO_REG_OUT     = 3'd1;
    localparam logic [2:0] GPIO_REG_DIR     = 3'd2;
    localparam logic [2:0] GPIO_REG_OUT_SET = 3'd3;
    localparam logic [2:0] GPIO_REG_OUT_CLR = 3'd4;
    localparam logic [2:0] GPIO_REG_RISE_EN = 3'd5;
    localparam logic [2:0] GPIO_REG_FALL_EN = 3'd6;
    localparam logic [2:0] GPIO_REG_STATUS  = 3'd7;

    localparam logic [31:0] GPIO_REG_RESET = 32'h0000_0000;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{sel[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_gpio_irq_if.sv
// rtl/wb_gpio_irq_if.sv - Wishbone classic slave bus bundle for wb_gpio_irq
interface wb_gpio_irq_if;

    logic [2:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - input synchroniser, optional debounce (WB_GPIO_DEBOUNCE_EN), registered edge detect
module gpio_sync_edge #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] filt_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] s, filt;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], gpio_i};
        s      = sync_q[SYNC_STAGES-1];
    end

`ifdef WB_GPIO_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tick;
    logic [WIDTH-1:0] samp_q, samp_d;
    logic [WIDTH-1:0] filt_q, filt_d;

    // A bit follows s only when two consecutive tick samples agree.
    always_comb begin
        tick   = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        cnt_d  = tick ? '0 : cnt_q + CW'(1);
        samp_d = tick ? s : samp_q;
        filt_d = filt_q;
        if (tick) begin
            filt_d = (s & ~(s ^ samp_q)) | (filt_q & (s ^ samp_q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            samp_q <= '0;
            filt_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            samp_q <= samp_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;
`else
    if (DEBOUNCE_CYCLES < 1) begin : g_debounce_cfg_unused
    end

    assign filt = s;
`endif

    always_comb begin
        p_d    = filt;
        rise_d = filt & ~p_q;
        fall_d = ~filt & p_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            p_q    <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q <= sync_d;
            p_q    <= p_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign filt_o = filt;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/wb_gpio_irq.sv
// rtl/wb_gpio_irq.sv - Wishbone GPIO with set/clear, edge interrupts and W1C status; debounce via WB_GPIO_DEBOUNCE_EN
module wb_gpio_irq
    import wb_gpio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    wb_gpio_irq_if.slave     wb,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_dir_o,
    output logic             irq_o
);

    localparam logic [0:0] BUS_IDLE = 1'b0;
    localparam logic [0:0] BUS_ACK  = 1'b1;
    localparam logic [31:0] WMASK = (WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'h1 << WIDTH) - 32'h1);

    logic [0:0]  state_q, state_d;
    logic [31:0] dat_o_q, dat_o_d;
    logic [31:0] out_q, out_d;
    logic [31:0] dir_q, dir_d;
    logic [31:0] rise_en_q, rise_en_d;
    logic [31:0] fall_en_q, fall_en_d;
    logic [31:0] status_q, status_d;
    logic        irq_q, irq_d;

    logic [WIDTH-1:0] in_val, rise, fall;
    logic [31:0] in32, rise32, fall32;
    logic [31:0] wmask, wdata, clr, rdata;
    logic        access, wr;

    gpio_sync_edge #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync_edge (
        .clk   (wb_clk),
        .rst   (wb_rst),
        .gpio_i(gpio_i),
        .filt_o(in_val),
        .rise_o(rise),
        .fall_o(fall)
    );

    always_comb begin
        in32   = '0;
        rise32 = '0;
        fall32 = '0;
        in32[WIDTH-1:0]   = in_val;
        rise32[WIDTH-1:0] = rise;
        fall32[WIDTH-1:0] = fall;

        // Only the first cycle of a request is serviced; the ack cycle is dead time.
        access = wb.wb_cyc_i & wb.wb_stb_i & (state_q == BUS_IDLE);
        wr     = access & wb.wb_we_i;
        wmask  = byte_mask(wb.wb_sel_i) & WMASK;
        wdata  = wb.wb_dat_i & wmask;

        unique case (wb.wb_adr_i)
            GPIO_REG_IN:      rdata = in32;
            GPIO_REG_OUT:     rdata = out_q;
            GPIO_REG_DIR:     rdata = dir_q;
            GPIO_REG_RISE_EN: rdata = rise_en_q;
            GPIO_REG_FALL_EN: rdata = fall_en_q;
            GPIO_REG_STATUS:  rdata = status_q;
            default:          rdata = '0;
        endcase

        state_d   = access ? BUS_ACK : BUS_IDLE;
        dat_o_d   = (access & ~wb.wb_we_i) ? rdata : dat_o_q;
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;

        if (wr) begin
            unique case (wb.wb_adr_i)
                GPIO_REG_OUT:     out_d     = (out_q & ~wmask) | wdata;
                GPIO_REG_DIR:     dir_d     = (dir_q & ~wmask) | wdata;
                GPIO_REG_OUT_SET: out_d     = out_q | wdata;
                GPIO_REG_OUT_CLR: out_d     = out_q & ~wdata;
                GPIO_REG_RISE_EN: rise_en_d = (rise_en_q & ~wmask) | wdata;
                GPIO_REG_FALL_EN: fall_en_d = (fall_en_q & ~wmask) | wdata;
                GPIO_REG_STATUS:  clr       = wdata;
                default:          ;
            endcase
        end

        // New events are ORed in after the clear so a same-cycle edge survives W1C.
        status_d = (status_q & ~clr) | (rise32 & rise_en_q) | (fall32 & fall_en_q);
        irq_d    = |status_q;
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q   <= BUS_IDLE;
            dat_o_q   <= GPIO_REG_RESET;
            out_q     <= GPIO_REG_RESET;
            dir_q     <= GPIO_REG_RESET;
            rise_en_q <= GPIO_REG_RESET;
            fall_en_q <= GPIO_REG_RESET;
            status_q  <= GPIO_REG_RESET;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dat_o_q   <= dat_o_d;
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            irq_q     <= irq_d;
        end
    end

    assign wb.wb_dat_o = dat_o_q;
    assign wb.wb_ack_o = (state_q == BUS_ACK);
    assign gpio_o      = out_q[WIDTH-1:0];
    assign gpio_dir_o  = dir_q[WIDTH-1:0];
    assign irq_o       = irq_q;

endmodule
